// File: rtl/irq_controller.sv
// irq_controller
//   Collects level interrupt requests from peripherals, masks them with the
//   per-line enables, and arbitrates between them. It presents one trap
//   request plus an mcause value to the core. When the core executes mret,
//   it returns a one-cycle completion pulse to the serviced peripheral.
//   Only one interrupt is in service at a time; there is no nesting.
//
//   Optional feature macro: IRQ_RR_EN
//     defined   -> round-robin arbitration, starting the search at rr_q
//     undefined -> fixed priority, lowest index wins (no rr_q state)
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   int_req_i  [N_IRQ] level requests, held until that line's int_fin
//   mie_i      [N_IRQ] per-line enable
//   irq_o      trap request to the core
//   irq_ack_i  core took the trap (pulse)
//   mret_i     core executed mret (pulse)
//   mcause_o   [32] cause of the current or last interrupt
//   int_fin_o  [N_IRQ] one-hot completion pulse
//   busy_o     high in any state other than IDLE
module irq_controller #(
  parameter int          N_IRQ       = 16,
  parameter logic [31:0] MCAUSE_BASE = 32'h8000_0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] int_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  output logic             irq_o,
  input  logic             irq_ack_i,
  input  logic             mret_i,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] int_fin_o,
  output logic             busy_o
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVE, FIN} state_t;

  state_t           state_q, state_d;
  logic             irq_q, irq_d;
  logic             busy_q, busy_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [N_IRQ-1:0] fin_q, fin_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [N_IRQ-1:0] pending;
  logic             win_vld;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  idx;

  assign pending = int_req_i & mie_i;

`ifdef IRQ_RR_EN
  logic [ID_W-1:0] rr_q, rr_d;

  // Walk the request vector starting at rr_q and wrap around; the first
  // set bit wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      idx = ID_W'((int'(rr_q) + i) % N_IRQ);
      if (!win_vld && pending[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end
`else
  // Fixed priority: the lowest set index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      idx = ID_W'(i);
      if (!win_vld && pending[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    id_d     = id_q;
    mcause_d = mcause_q;
    fin_d    = '0;
`ifdef IRQ_RR_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          id_d     = win_idx;
          mcause_d = MCAUSE_BASE + 32'(win_idx);
          irq_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // An ack takes precedence over a withdrawal in the same cycle.
        if (irq_ack_i) begin
          irq_d   = 1'b0;
          state_d = SERVE;
        end else if (!pending[id_q]) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVE: begin
        if (mret_i) state_d = FIN;
      end
      FIN: begin
        // FIN spans two cycles. In the first cycle, the pulse is registered.
        // In the second cycle, the pulse is visible, and the peripheral drops
        // its request on the closing edge. IDLE then samples a line that is
        // already cleared.
        if (fin_q == '0) begin
          fin_d[id_q] = 1'b1;
        end else begin
          state_d = IDLE;
`ifdef IRQ_RR_EN
          rr_d = (id_q == ID_W'(N_IRQ - 1)) ? '0 : id_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      busy_q   <= 1'b0;
      mcause_q <= '0;
      fin_q    <= '0;
      id_q     <= '0;
`ifdef IRQ_RR_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      busy_q   <= busy_d;
      mcause_q <= mcause_d;
      fin_q    <= fin_d;
      id_q     <= id_d;
`ifdef IRQ_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign irq_o     = irq_q;
  assign busy_o    = busy_q;
  assign mcause_o  = mcause_q;
  assign int_fin_o = fin_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (default parameters). Inputs change on
// the falling edge, and outputs are checked on the falling edge after each
// rising edge.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] int_req, mie, int_fin;
  logic        irq, irq_ack, mret, busy;
  logic [31:0] mcause;

  int n_chk  = 0;
  int n_fail = 0;

  irq_controller dut (
    .clk       (clk),
    .rst       (rst),
    .int_req_i (int_req),
    .mie_i     (mie),
    .irq_o     (irq),
    .irq_ack_i (irq_ack),
    .mret_i    (mret),
    .mcause_o  (mcause),
    .int_fin_o (int_fin),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; int_req = '0; mie = '1; irq_ack = 1'b0; mret = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Run the ack and mret handshake from REQ, then check the fin pulse.
  // The fin bit is dropped from int_req only if drop is set.
  task automatic serve(input string tag, input logic [15:0] exp_fin, input bit drop);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk({tag, " irq after ack"}, {31'b0, irq}, 32'd0);
    chk({tag, " busy in serve"}, {31'b0, busy}, 32'd1);
    tick(); tick();
    chk({tag, " no fin in serve"}, {16'b0, int_fin}, 32'd0);
    mret = 1'b1; tick(); mret = 1'b0;
    chk({tag, " fin not yet"}, {16'b0, int_fin}, 32'd0);
    tick();
    chk({tag, " fin pulse"}, {16'b0, int_fin}, {16'b0, exp_fin});
    if (drop) int_req = int_req & ~exp_fin;
    tick();
    chk({tag, " fin one cycle"}, {16'b0, int_fin}, 32'd0);
    chk({tag, " idle after fin"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst irq", {31'b0, irq}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst mcause", mcause, 32'd0);
    chk("rst fin", {16'b0, int_fin}, 32'd0);
    // mret and ack are ignored while IDLE
    mret = 1'b1; irq_ack = 1'b1; tick(); mret = 1'b0; irq_ack = 1'b0;
    chk("idle ignore busy", {31'b0, busy}, 32'd0);
    chk("idle ignore fin", {16'b0, int_fin}, 32'd0);

    // 1: single request on line 3
    int_req[3] = 1'b1; tick();
    chk("t1 irq", {31'b0, irq}, 32'd1);
    chk("t1 mcause", mcause, 32'h8000_0013);
    chk("t1 busy", {31'b0, busy}, 32'd1);
    mret = 1'b1; tick(); mret = 1'b0;
    chk("t1 irq held", {31'b0, irq}, 32'd1);
    serve("t1", 16'h0008, 1'b1);
    chk("t1 mcause held", mcause, 32'h8000_0013);

    // 2: fixed priority between lines 2 and 5
    do_reset();
    int_req = 16'h0024; tick();
    chk("t2 first mcause", mcause, 32'h8000_0012);
    serve("t2a", 16'h0004, 1'b1);
    tick();
    chk("t2 second irq", {31'b0, irq}, 32'd1);
    chk("t2 second mcause", mcause, 32'h8000_0015);
    serve("t2b", 16'h0020, 1'b1);

    // 3: masking
    do_reset();
    int_req[4] = 1'b1; mie[4] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3 masked irq", {31'b0, irq}, 32'd0);
    end
    mie[4] = 1'b1; tick();
    chk("t3 unmasked irq", {31'b0, irq}, 32'd1);
    chk("t3 mcause", mcause, 32'h8000_0014);
    serve("t3", 16'h0010, 1'b1);

    // 4: withdrawal by masking, then a same-cycle ack that wins
    do_reset();
    int_req[7] = 1'b1; tick();
    chk("t4 irq", {31'b0, irq}, 32'd1);
    chk("t4 mcause", mcause, 32'h8000_0017);
    mie[7] = 1'b0; tick();
    chk("t4 withdrawn irq", {31'b0, irq}, 32'd0);
    chk("t4 withdrawn busy", {31'b0, busy}, 32'd0);
    tick();
    chk("t4 no fin", {16'b0, int_fin}, 32'd0);
    mie[7] = 1'b1; tick();
    chk("t4 reissued irq", {31'b0, irq}, 32'd1);
    mie[7] = 1'b0; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t4 ack wins irq", {31'b0, irq}, 32'd0);
    chk("t4 ack wins busy", {31'b0, busy}, 32'd1);
    mie[7] = 1'b1;
    mret = 1'b1; tick(); mret = 1'b0; tick();
    chk("t4 fin", {16'b0, int_fin}, 32'h0000_0080);
    int_req[7] = 1'b0; tick();

    // 5: lines 0 and 1 stay asserted across four services
    do_reset();
    int_req = 16'h0003;
    for (int s = 0; s < 4; s++) begin
      logic [15:0] ef;
`ifdef IRQ_RR_EN
      ef = (s % 2 == 0) ? 16'h0001 : 16'h0002;
`else
      ef = 16'h0001;
`endif
      tick();
      chk("t5 irq", {31'b0, irq}, 32'd1);
      chk("t5 mcause", mcause, (ef == 16'h0001) ? 32'h8000_0010 : 32'h8000_0011);
      serve("t5", ef, 1'b0);
    end
    int_req = '0; tick();

    // 6: reset during SERVE
    do_reset();
    int_req[9] = 1'b1; tick();
    chk("t6 mcause", mcause, 32'h8000_0019);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t6 in serve", {31'b0, busy}, 32'd1);
    rst = 1'b1; mret = 1'b1; tick(); mret = 1'b0; rst = 1'b0;
    chk("t6 rst irq", {31'b0, irq}, 32'd0);
    chk("t6 rst busy", {31'b0, busy}, 32'd0);
    chk("t6 rst mcause", mcause, 32'd0);
    chk("t6 rst fin", {16'b0, int_fin}, 32'd0);
    tick();
    chk("t6 reissue irq", {31'b0, irq}, 32'd1);
    chk("t6 reissue mcause", mcause, 32'h8000_0019);
    chk("t6 reissue no fin", {16'b0, int_fin}, 32'd0);
    serve("t6", 16'h0200, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
